// File: rtl/aes_decipher_block_if.sv
// Cipher-side handshake of the AES inverse cipher: start pulse, ciphertext in,
// plaintext out and the ready/idle flag.
interface aes_decipher_block_if;
   logic         next;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   modport master (output next, output block, input new_block, input ready);
   modport slave  (input next, input block, output new_block, output ready);
endinterface

// File: rtl/aes_decipher_block.sv
// Iterative AES inverse cipher: one AddRoundKey, then NR rounds of
// word-serial InvSubBytes (4 cycles) plus InvShiftRows/AddRoundKey/InvMixColumns (1 cycle).
// Optional macro DEC_OUT_MASK_EN forces new_block to zero while busy.
module aes_decipher_block #(
   parameter int NR = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   aes_decipher_block_if.slave   dec,
   output logic [3:0]            round,
   input  logic [127:0]          round_key,
   output logic [31:0]           inv_sboxw,
   input  logic [31:0]           new_inv_sboxw
);

   localparam logic [3:0] NR_L = 4'(NR);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      SBOX = 2'd2,
      MAIN = 2'd3
   } state_e;

   state_e       fsm_q, fsm_d;
   logic [127:0] s_q, s_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   widx_q, widx_d;
   logic         ready_q, ready_d;
   logic [127:0] t_s;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
              inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
   endfunction

   // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   // Word of the state currently routed to the external inverse S-box.
   always_comb begin
      case (widx_q)
         2'd0:    inv_sboxw = s_q[127:96];
         2'd1:    inv_sboxw = s_q[95:64];
         2'd2:    inv_sboxw = s_q[63:32];
         2'd3:    inv_sboxw = s_q[31:0];
         default: inv_sboxw = 32'h0;
      endcase
   end

   // Next-state and datapath; round_q doubles as the round counter.
   always_comb begin
      fsm_d   = fsm_q;
      s_d     = s_q;
      round_d = round_q;
      widx_d  = widx_q;
      ready_d = ready_q;
      t_s     = inv_shift_rows(s_q) ^ round_key;
      case (fsm_q)
         IDLE: begin
            if (dec.next) begin
               s_d     = dec.block;
               ready_d = 1'b0;
               round_d = NR_L;
               fsm_d   = INIT;
            end else begin
               fsm_d   = IDLE;
            end
         end
         INIT: begin
            s_d     = s_q ^ round_key;
            round_d = NR_L - 4'd1;
            widx_d  = 2'd0;
            fsm_d   = SBOX;
         end
         SBOX: begin
            case (widx_q)
               2'd0:    s_d[127:96] = new_inv_sboxw;
               2'd1:    s_d[95:64]  = new_inv_sboxw;
               2'd2:    s_d[63:32]  = new_inv_sboxw;
               2'd3:    s_d[31:0]   = new_inv_sboxw;
               default: s_d         = s_q;
            endcase
            widx_d = widx_q + 2'd1;
            if (widx_q == 2'd3) begin
               fsm_d = MAIN;
            end else begin
               fsm_d = SBOX;
            end
         end
         MAIN: begin
            if (round_q != 4'd0) begin
               s_d     = inv_mix_columns(t_s);
               round_d = round_q - 4'd1;
               fsm_d   = SBOX;
            end else begin
               s_d     = t_s;
               ready_d = 1'b1;
               fsm_d   = IDLE;
            end
         end
         default: begin
            fsm_d   = IDLE;
            round_d = 4'd0;
            widx_d  = 2'd0;
            ready_d = 1'b1;
         end
      endcase
   end

   // State registers with asynchronous abort to the idle/reset values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= IDLE;
         s_q     <= 128'h0;
         round_q <= 4'd0;
         widx_q  <= 2'd0;
         ready_q <= 1'b1;
      end else begin
         fsm_q   <= fsm_d;
         s_q     <= s_d;
         round_q <= round_d;
         widx_q  <= widx_d;
         ready_q <= ready_d;
      end
   end

   assign round     = round_q;
   assign dec.ready = ready_q;

`ifdef DEC_OUT_MASK_EN
   assign dec.new_block = ready_q ? s_q : 128'h0;
`else
   assign dec.new_block = s_q;
`endif

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed bench for aes_decipher_block with FIPS-197 vectors, a behavioural
// AES-128 key schedule and a computed inverse S-box.
module tb_aes_decipher_block;

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  inv_sboxw;
   logic [31:0]  new_inv_sboxw;

   logic [7:0]   isb [0:255];
   logic [127:0] rk  [0:15];

   int checks = 0;
   int errors = 0;
   int lat;
   int busy_nz = 0;
   logic rounds_ok;

   always #5 clk = ~clk;

   aes_decipher_block_if dif ();

   aes_decipher_block #(.NR(10)) dut (
      .clk           (clk),
      .reset         (reset),
      .dec           (dif.slave),
      .round         (round),
      .round_key     (round_key),
      .inv_sboxw     (inv_sboxw),
      .new_inv_sboxw (new_inv_sboxw)
   );

   always_comb begin
      round_key = rk[round];
   end

   assign new_inv_sboxw = {isb[inv_sboxw[31:24]], isb[inv_sboxw[23:16]],
                           isb[inv_sboxw[15:8]],  isb[inv_sboxw[7:0]]};

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return (a == 8'h00) ? 8'h00 : r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   task automatic set_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = 128'h0;
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while idle; returns at the negedge after E0.
   task automatic launch(input logic [127:0] blk);
      dif.next  = 1'b1;
      dif.block = blk;
      @(posedge clk);
      @(negedge clk);
      dif.next  = 1'b0;
      dif.block = ~blk;
      check("init_round", {124'h0, round}, 128'd10);
      if (!dif.ready && dif.new_block != 128'h0) busy_nz++;
   endtask

   // Counts edges E1.. until ready; optional next pulse at edge pulse_at, early return at reset_at.
   task automatic run_wait(input int pulse_at, input int reset_at, output int n);
      int exp_round;
      n = 0;
      rounds_ok = 1'b1;
      while (n < 200) begin
         if (n + 1 == pulse_at) begin
            dif.next  = 1'b1;
            dif.block = 128'hdeadbeef_cafef00d_01234567_89abcdef;
         end
         @(posedge clk);
         n++;
         @(negedge clk);
         dif.next = 1'b0;
         if (n == reset_at) return;
         exp_round = (n <= 50) ? 9 - (n - 1) / 5 : 0;
         if (int'(round) != exp_round) rounds_ok = 1'b0;
         if (!dif.ready && dif.new_block != 128'h0) busy_nz++;
         if (dif.ready) break;
      end
   endtask

   initial begin
      reset     = 1'b1;
      dif.next  = 1'b0;
      dif.block = 128'h0;
      for (int i = 0; i < 256; i++) isb[i] = ginv(rotl8(8'(i), 1) ^ rotl8(8'(i), 3) ^ rotl8(8'(i), 6) ^ 8'h05);
      set_key(K1);
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", {127'h0, dif.ready}, 128'd1);
      check("rst_new_block", dif.new_block, 128'h0);
      check("rst_round", {124'h0, round}, 128'd0);
      check("rst_inv_sboxw", {96'h0, inv_sboxw}, 128'h0);
      reset = 1'b0;
      @(negedge clk);

      // FIPS-197 C.1 decrypt
      launch(C1);
      run_wait(0, 0, lat);
      check("c1_latency", lat, 128'd51);
      check("c1_result", dif.new_block, P1);
      check("c1_round_seq", {127'h0, rounds_ok}, 128'd1);

      // Back-to-back start in the first ready cycle, new key
      set_key(KB);
      launch(CB);
      run_wait(0, 0, lat);
      check("b2b_latency", lat, 128'd51);
      check("b2b_result", dif.new_block, PB);

      // Reset while idle with a result held
      #2;
      reset = 1'b1;
      #1;
      check("idle_rst_ready", {127'h0, dif.ready}, 128'd1);
      check("idle_rst_new_block", dif.new_block, 128'h0);
      check("idle_rst_round", {124'h0, round}, 128'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Abort at E30, then restart
      set_key(K1);
      launch(C1);
      run_wait(0, 30, lat);
      reset = 1'b1;
      #1;
      check("run_rst_ready", {127'h0, dif.ready}, 128'd1);
      check("run_rst_new_block", dif.new_block, 128'h0);
      check("run_rst_round", {124'h0, round}, 128'd0);
      check("run_rst_inv_sboxw", {96'h0, inv_sboxw}, 128'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      launch(C1);
      run_wait(0, 0, lat);
      check("restart_latency", lat, 128'd51);
      check("restart_result", dif.new_block, P1);
      check("restart_round_seq", {127'h0, rounds_ok}, 128'd1);

      // next while busy is ignored
      @(negedge clk);
      launch(C1);
      run_wait(20, 0, lat);
      check("busy_next_latency", lat, 128'd51);
      check("busy_next_result", dif.new_block, P1);
      repeat (6) @(negedge clk);
      check("busy_next_no_rerun", {127'h0, dif.ready}, 128'd1);
      check("busy_next_hold", dif.new_block, P1);
      check("busy_next_round", {124'h0, round}, 128'd0);

`ifdef DEC_OUT_MASK_EN
      check("busy_masked", busy_nz, 128'd0);
`else
      check("busy_visible", {127'h0, busy_nz != 0}, 128'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
